seq_game_ctrl: RTL

//  Parametrised memory-sequence game controller: grows a random colour sequence one step per

---
 rtl/seq_game_ctrl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/seq_game_ctrl.sv
// seq_game_ctrl: memory-sequence game FSM that grows, replays and checks a colour sequence.
// Defining SEQ_GAME_RETRY_EN allows one replay per game after the first miss.
module seq_game_ctrl #(
  parameter int COLOR_W      = 2,
  parameter int MAX_LEN      = 32,
  parameter int LEN_W        = 6,
  parameter int TURN_TIMEOUT = 5
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START_GAME,
  input  logic [COLOR_W-1:0] IN,
  input  logic               IN_VALID,
  input  logic [COLOR_W-1:0] RAND,
  input  logic               TIMER_PULSE,
  output logic               TIMER_GO,
  output logic [COLOR_W-1:0] OUT,
  output logic               OUT_ENA,
  output logic               WIN,
  output logic               LOSE,
  output logic               HS,
  output logic [LEN_W-1:0]   SCORE,
  output logic [LEN_W-1:0]   HIGH_SCORE
);
  localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMO_W  = $clog2(TURN_TIMEOUT + 1);
  localparam logic [LEN_W-1:0] LAST_LEN  = LEN_W'(MAX_LEN - 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TURN_TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_START  = 4'd1,
    S_ADD    = 4'd2,
    S_SHOW   = 4'd3,
    S_SHOW_W = 4'd4,
    S_INPUT  = 4'd5,
    S_HOLD   = 4'd6,
    S_WIN    = 4'd7,
    S_LOSE   = 4'd8,
`ifdef SEQ_GAME_RETRY_EN
    S_REPLAY = 4'd10,
`endif
    S_END    = 4'd9
  } state_t;

  state_t             state_reg;
  state_t             miss_state;
  logic [LEN_W-1:0]   idx_reg;
  logic [LEN_W-1:0]   len_reg;
  logic [TMO_W-1:0]   tmo_reg;
  logic [TMO_W-1:0]   tmo_next;
  logic               match_reg;
  logic [COLOR_W-1:0] out_reg;
  logic               out_ena_reg;
  logic               timer_go_reg;
  logic               win_reg;
  logic               lose_reg;
  logic               hs_reg;
  logic [LEN_W-1:0]   score_reg;
  logic [LEN_W-1:0]   high_score_reg;
`ifdef SEQ_GAME_RETRY_EN
  logic               retry_used_reg;
`endif

  // Shallow table read combinationally so SHOW and INPUT see seq[idx] in the same cycle.
  logic [COLOR_W-1:0] seq_mem [MAX_LEN];
  logic [COLOR_W-1:0] seq_rd;

  assign seq_rd   = seq_mem[idx_reg[ADDR_W-1:0]];
  assign tmo_next = tmo_reg + TMO_W'(1);

  always_ff @(posedge CLK) begin
    if (state_reg == S_ADD)
      seq_mem[len_reg[ADDR_W-1:0]] <= RAND;
  end

  always_comb begin
    miss_state = S_LOSE;
`ifdef SEQ_GAME_RETRY_EN
    if (!retry_used_reg)
      miss_state = S_REPLAY;
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= S_IDLE;
      idx_reg        <= '0;
      len_reg        <= '0;
      tmo_reg        <= '0;
      match_reg      <= 1'b0;
      out_reg        <= '1;
      out_ena_reg    <= 1'b0;
      timer_go_reg   <= 1'b0;
      win_reg        <= 1'b0;
      lose_reg       <= 1'b0;
      hs_reg         <= 1'b0;
      score_reg      <= '0;
      high_score_reg <= '0;
`ifdef SEQ_GAME_RETRY_EN
      retry_used_reg <= 1'b0;
`endif
    end else begin
      timer_go_reg <= 1'b0;
      win_reg      <= 1'b0;
      lose_reg     <= 1'b0;
      hs_reg       <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          idx_reg <= '0;
          len_reg <= '0;
          if (START_GAME) state_reg <= S_START;
        end
        S_START: begin
          score_reg <= '0;
`ifdef SEQ_GAME_RETRY_EN
          retry_used_reg <= 1'b0;
`endif
          if (!START_GAME) state_reg <= S_ADD;
        end
        S_ADD: begin
          idx_reg   <= '0;
          state_reg <= S_SHOW;
        end
        S_SHOW: begin
          out_reg      <= seq_rd;
          out_ena_reg  <= 1'b1;
          timer_go_reg <= 1'b1;
          state_reg    <= S_SHOW_W;
        end
        S_SHOW_W: begin
          if (TIMER_PULSE) begin
            out_ena_reg <= 1'b0;
            if (idx_reg == len_reg) begin
              idx_reg      <= '0;
              tmo_reg      <= '0;
              timer_go_reg <= 1'b1;
              state_reg    <= S_INPUT;
            end else begin
              idx_reg   <= idx_reg + LEN_W'(1);
              state_reg <= S_SHOW;
            end
          end
        end
        S_INPUT: begin
          // A press in the same cycle as the final tick takes priority over the timeout.
          if (IN_VALID) begin
            match_reg <= (IN == seq_rd);
            state_reg <= S_HOLD;
          end else if (TIMER_PULSE) begin
            tmo_reg <= tmo_next;
            if (tmo_next == TMO_LIMIT) state_reg <= miss_state;
          end
        end
        S_HOLD: begin
          if (!IN_VALID) begin
            if (!match_reg) begin
              state_reg <= miss_state;
            end else if (idx_reg != len_reg) begin
              idx_reg      <= idx_reg + LEN_W'(1);
              tmo_reg      <= '0;
              timer_go_reg <= 1'b1;
              state_reg    <= S_INPUT;
            end else begin
              score_reg <= len_reg + LEN_W'(1);
              if (len_reg == LAST_LEN) begin
                state_reg <= S_WIN;
              end else begin
                len_reg   <= len_reg + LEN_W'(1);
                state_reg <= S_ADD;
              end
            end
          end
        end
`ifdef SEQ_GAME_RETRY_EN
        S_REPLAY: begin
          idx_reg        <= '0;
          retry_used_reg <= 1'b1;
          state_reg      <= S_SHOW;
        end
`endif
        S_WIN: begin
          win_reg   <= 1'b1;
          state_reg <= S_END;
        end
        S_LOSE: begin
          lose_reg  <= 1'b1;
          state_reg <= S_END;
        end
        S_END: begin
          if (score_reg > high_score_reg) begin
            high_score_reg <= score_reg;
            hs_reg         <= 1'b1;
          end
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign TIMER_GO   = timer_go_reg;
  assign OUT        = out_reg;
  assign OUT_ENA    = out_ena_reg;
  assign WIN        = win_reg;
  assign LOSE       = lose_reg;
  assign HS         = hs_reg;
  assign SCORE      = score_reg;
  assign HIGH_SCORE = high_score_reg;
endmodule
